r5p_bus_copy: RTL and testbench

Bus manager copy engine for the r5p load/store bus. Given a source address, destination address and byte length, it reads full data words from memory and writes them back out one word at a time, acting as the initiator on an `r5p_bus_if` subordinate such as the testbench memory model. It sits beside the core on a shared load/store path, or alone in a bench, to move or preset memory contents without CPU involvement.

---
 rtl/r5p_bus_copy_if.sv | 22 ++
 rtl/r5p_bus_copy.sv | 131 +++++++++++++
 tb/tb_r5p_bus_copy.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/r5p_bus_copy_if.sv
// r5p_bus_if: r5p load/store bus; the manager drives the request, the subordinate answers
//   clk : bus clock
//   vld/wen/adr/ben/wdt : request from the manager (transfer on vld & rdy)
//   rdt : read data, valid the cycle after a read transfer
//   rdy : subordinate accepts the request this cycle
interface r5p_bus_if #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input logic clk
);
    localparam int BW = DW / 8;
    logic          vld;
    logic          wen;
    logic [AW-1:0] adr;
    logic [BW-1:0] ben;
    logic [DW-1:0] wdt;
    logic [DW-1:0] rdt;
    logic          rdy;
    modport man (input clk, output vld, wen, adr, ben, wdt, input rdt, rdy);
    modport sub (input clk, vld, wen, adr, ben, wdt, output rdt, rdy);
endinterface

// File: rtl/r5p_bus_copy.sv
// r5p_bus_copy: word-by-word memory copy engine acting as manager on an r5p_bus_if
//   clk, rst     : clock and synchronous active-high reset
//   start        : begin a transfer (sampled only when idle)
//   src/dst/len  : source, destination (word aligned internally) and byte length
//   fill/pat     : fill mode request and pattern, honoured only with R5P_BUS_COPY_FILL_EN
//   busy/done    : transfer in progress / one-cycle completion pulse
//   man          : bus manager port
module r5p_bus_copy #(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int LW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] src,
    input  logic [AW-1:0] dst,
    input  logic [LW-1:0] len,
    input  logic          fill,
    input  logic [DW-1:0] pat,
    output logic          busy,
    output logic          done,
    r5p_bus_if.man        man
);
    localparam int BW = DW / 8;
    localparam int SH = $clog2(BW);
    localparam int CW = LW - SH;

    typedef enum logic [2:0] {IDLE, READ, CAPT, WRITE, DONE} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] src_q, src_d, dst_q, dst_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] buf_q, buf_d;
    logic          xfer;

    assign xfer    = man.vld & man.rdy;
    assign man.ben = '1;

`ifdef R5P_BUS_COPY_FILL_EN
    logic          fill_q, fill_d;
    logic [DW-1:0] pat_q, pat_d;
    logic [SH-1:0] unused_len;
    assign unused_len = len[SH-1:0];
`else
    logic unused_ok;
    assign unused_ok = ^{fill, pat, len[SH-1:0]};
`endif

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
`ifdef R5P_BUS_COPY_FILL_EN
        fill_d  = fill_q;
        pat_d   = pat_q;
`endif
        case (state_q)
            IDLE: if (start) begin
                src_d = src & ~AW'(BW - 1);
                dst_d = dst & ~AW'(BW - 1);
                cnt_d = len[LW-1:SH];
`ifdef R5P_BUS_COPY_FILL_EN
                fill_d  = fill;
                pat_d   = pat;
                state_d = cnt_d == '0 ? DONE : fill ? WRITE : READ;
`else
                state_d = cnt_d == '0 ? DONE : READ;
`endif
            end
            READ: state_d = xfer ? CAPT : READ;
            CAPT: begin
                buf_d   = man.rdt;
                state_d = WRITE;
            end
            WRITE: if (xfer) begin
                src_d = src_q + AW'(BW);
                dst_d = dst_q + AW'(BW);
                cnt_d = cnt_q - CW'(1);
`ifdef R5P_BUS_COPY_FILL_EN
                state_d = cnt_d == '0 ? DONE : fill_q ? WRITE : READ;
`else
                state_d = cnt_d == '0 ? DONE : READ;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // Bus outputs are registered from the next state so nothing on the bus
    // depends combinationally on start or rdt.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            cnt_q   <= '0;
            buf_q   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            man.vld <= 1'b0;
            man.wen <= 1'b0;
            man.adr <= '0;
            man.wdt <= '0;
`ifdef R5P_BUS_COPY_FILL_EN
            fill_q  <= 1'b0;
            pat_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
            busy    <= state_d != IDLE;
            done    <= state_d == DONE;
            man.vld <= state_d == READ || state_d == WRITE;
            man.wen <= state_d == WRITE;
            man.adr <= state_d == WRITE ? dst_d : src_d;
`ifdef R5P_BUS_COPY_FILL_EN
            fill_q  <= fill_d;
            pat_q   <= pat_d;
            man.wdt <= fill_d ? pat_d : buf_d;
`else
            man.wdt <= buf_d;
`endif
        end
    end
endmodule

// File: tb/tb_r5p_bus_copy.sv
// tb_r5p_bus_copy: scoreboard bench for r5p_bus_copy with a one-cycle-latency memory model
module tb_r5p_bus_copy;
    typedef struct {
        logic        wen;
        logic [31:0] adr;
        logic [31:0] wdt;
    } txn_t;

    logic        clk = 0, rst = 1, start = 0, fill = 0, mem_clr = 0;
    logic        busy, done;
    logic [31:0] src = 0, dst = 0, pat = 0;
    logic [15:0] len = 0;
    logic [31:0] mem [1024];
    logic [31:0] w [4];
    txn_t        exp_q [$];
    int          n_vec = 0, n_err = 0;

    always #5 clk = ~clk;

    r5p_bus_if #(.AW(32), .DW(32)) bus (.clk(clk));

    r5p_bus_copy #(.AW(32), .DW(32), .LW(16)) dut (
        .clk(clk), .rst(rst), .start(start), .src(src), .dst(dst), .len(len),
        .fill(fill), .pat(pat), .busy(busy), .done(done), .man(bus)
    );

    always @(posedge bus.clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 32'h0;
            mem[64] <= 32'h11223344;
            mem[65] <= 32'h55667788;
            mem[66] <= 32'h99AABBCC;
            mem[67] <= 32'hDDEEFF00;
        end else if (bus.vld && bus.rdy) begin
            if (bus.wen) mem[bus.adr[11:2]] <= bus.wdt;
            else bus.rdt <= mem[bus.adr[11:2]];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] rd(input logic [31:0] a);
        return mem[a[11:2]];
    endfunction

    task automatic push_copy(input logic [31:0] s, input logic [31:0] d, input int n);
        for (int k = 0; k < n; k++) begin
            exp_q.push_back('{1'b0, s + 32'(4 * k), 32'h0});
            exp_q.push_back('{1'b1, d + 32'(4 * k), w[k]});
        end
    endtask

    task automatic run(input string nm, input logic [31:0] s, input logic [31:0] d,
                       input logic [15:0] l, input logic f, input logic [63:0] stall,
                       input int exp_done, input int rst_at);
        int c = 1;
        bit seen = 0;
        bit busy_ok = 1;
        src = s; dst = d; len = l; fill = f; pat = 32'hDEADBEEF; start = 1;
        @(posedge clk); #1;
        start = 0;
        bus.rdy = !stall[1];
        while (!seen && c < 60) begin
            @(negedge clk);
            if (rst_at != 0 && c == rst_at + 1) begin
                chk({nm, " vld after rst"}, {31'b0, bus.vld}, 32'h0);
                chk({nm, " busy after rst"}, {31'b0, busy}, 32'h0);
                chk({nm, " done after rst"}, {31'b0, done}, 32'h0);
                rst = 0;
                seen = 1;
            end else begin
                if (busy !== 1'b1) busy_ok = 0;
                if (done === 1'b1) seen = 1;
            end
            if (!seen) begin
                @(posedge clk); #1;
                c++;
                bus.rdy = !stall[c];
                if (c == rst_at) rst = 1;
            end
        end
        bus.rdy = 1;
        if (rst_at == 0) begin
            chk({nm, " done cycle"}, seen ? 32'(c) : 32'h0, 32'(exp_done));
            chk({nm, " busy held"}, {31'b0, busy_ok}, 32'h1);
            @(negedge clk);
            chk({nm, " done pulse"}, {31'b0, done}, 32'h0);
            chk({nm, " busy cleared"}, {31'b0, busy}, 32'h0);
        end
        chk({nm, " pending"}, 32'(exp_q.size()), 32'h0);
    endtask

    initial begin
        w[0] = 32'h11223344; w[1] = 32'h55667788; w[2] = 32'h99AABBCC; w[3] = 32'hDDEEFF00;
        bus.rdy = 1;
        fork
            begin
                logic        stl = 0, rst_p = 0, h_wen = 0;
                logic [31:0] h_adr = 0, h_wdt = 0;
                txn_t        t;
                forever begin
                    @(negedge clk);
                    if (stl && !rst_p) begin
                        chk("hold vld", {31'b0, bus.vld}, 32'h1);
                        chk("hold wen", {31'b0, bus.wen}, {31'b0, h_wen});
                        chk("hold adr", bus.adr, h_adr);
                        chk("hold wdt", bus.wdt, h_wdt);
                    end
                    if (bus.vld === 1'b1 && bus.rdy === 1'b1) begin
                        if (exp_q.size() == 0) begin
                            n_vec++;
                            n_err++;
                            $display("FAIL unexpected xfer: got adr %h wen %b expected none", bus.adr, bus.wen);
                        end else begin
                            t = exp_q.pop_front();
                            chk("xfer wen", {31'b0, bus.wen}, {31'b0, t.wen});
                            chk("xfer adr", bus.adr, t.adr);
                            chk("xfer ben", {28'b0, bus.ben}, 32'hF);
                            if (t.wen) chk("xfer wdt", bus.wdt, t.wdt);
                        end
                    end
                    stl = bus.vld === 1'b1 && bus.rdy === 1'b0;
                    rst_p = rst;
                    h_wen = bus.wen; h_adr = bus.adr; h_wdt = bus.wdt;
                end
            end
        join_none

        mem_clr = 1;
        repeat (3) @(posedge clk);
        #1 mem_clr = 0;
        @(negedge clk);
        chk("rst busy", {31'b0, busy}, 32'h0);
        chk("rst done", {31'b0, done}, 32'h0);
        chk("rst vld", {31'b0, bus.vld}, 32'h0);
        chk("rst wen", {31'b0, bus.wen}, 32'h0);
        chk("rst adr", bus.adr, 32'h0);
        chk("rst wdt", bus.wdt, 32'h0);
        rst = 0;

        run("len0", 32'h100, 32'h200, 16'd0, 1'b0, 64'h0, 1, 0);
        run("len3", 32'h100, 32'h200, 16'd3, 1'b0, 64'h0, 1, 0);
        chk("len0/3 mem", rd(32'h200), 32'h0);

        start = 1; len = 0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("restart done", {31'b0, done}, 32'h1);
        @(posedge clk); #1 start = 0;
        @(negedge clk);
        chk("start in done busy", {31'b0, busy}, 32'h0);
        chk("start in done pulse", {31'b0, done}, 32'h0);

        push_copy(32'h100, 32'h204, 2);
        run("unaligned", 32'h103, 32'h207, 16'd9, 1'b0, 64'h0, 7, 0);
        chk("unaligned m204", rd(32'h204), w[0]);
        chk("unaligned m208", rd(32'h208), w[1]);
        chk("unaligned m200", rd(32'h200), 32'h0);
        chk("unaligned m20c", rd(32'h20C), 32'h0);

        push_copy(32'h100, 32'h200, 4);
        run("copy", 32'h100, 32'h200, 16'd16, 1'b0, 64'h0, 13, 0);
        for (int k = 0; k < 4; k++) chk("copy mem", rd(32'h200 + 32'(4 * k)), w[k]);

        push_copy(32'h100, 32'h200, 4);
        run("stall", 32'h100, 32'h200, 16'd16, 1'b0, 64'h4006, 16, 0);

        exp_q.push_back('{1'b0, 32'h100, 32'h0});
        exp_q.push_back('{1'b1, 32'h240, w[0]});
        exp_q.push_back('{1'b0, 32'h104, 32'h0});
        run("reset", 32'h100, 32'h240, 16'd16, 1'b0, 64'h40, 0, 6);
        chk("reset m240", rd(32'h240), w[0]);
        chk("reset m244", rd(32'h244), 32'h0);

        push_copy(32'h100, 32'h240, 4);
        run("after reset", 32'h100, 32'h240, 16'd16, 1'b0, 64'h0, 13, 0);
        chk("after reset m244", rd(32'h244), w[1]);
        chk("after reset m24c", rd(32'h24C), w[3]);

`ifdef R5P_BUS_COPY_FILL_EN
        for (int k = 0; k < 3; k++) exp_q.push_back('{1'b1, 32'h300 + 32'(4 * k), 32'hDEADBEEF});
        run("fill", 32'h100, 32'h300, 16'd12, 1'b1, 64'h0, 4, 0);
        for (int k = 0; k < 3; k++) chk("fill mem", rd(32'h300 + 32'(4 * k)), 32'hDEADBEEF);
`else
        push_copy(32'h100, 32'h300, 3);
        run("fill off", 32'h100, 32'h300, 16'd12, 1'b1, 64'h0, 10, 0);
        for (int k = 0; k < 3; k++) chk("fill off mem", rd(32'h300 + 32'(4 * k)), w[k]);
`endif
        chk("m30c untouched", rd(32'h30C), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
